dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
- Sequences data-memory loads and stores for the instruction in the MEM stage of the RV32I pipeline.
- Consumes the MEM-stage control bits (memwrite, load/store selects) and issues one request per access over a req/gnt/rvalid handshake.
- Stalls the pipeline until the access completes, generates byte enables and store-lane replication, and returns the sign/zero-extended load result to WB.
- Flags misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles spent in REQ+RESP before the access is aborted.
- CNT_W, 5: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- memwrite_m  in  1  MEM-stage store.
- memread_m  in  1  MEM-stage load.
- addr_m  in  32  byte address from ALU result.
- wdata_m  in  32  store data (rs2).
- load_sel_m  in  2  00=word, 01=half, 10=byte, 11=reserved (treated as word).
- load_uns_m  in  1  1=zero-extend (LBU/LHU).
- store_sel_m  in  3  one-hot: 001=SB, 010=SH, 100=SW.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1=write.
- dmem_addr  out  32  word-aligned address ({addr_m[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_gnt  in  1  memory accepts request this cycle.
- dmem_rvalid  in  1  response valid (read data or write ack).
- dmem_rdata  in  32  read word.
- stall_o  out  1  freeze IF..MEM, insert bubble into WB.
- load_data_w  out  32  extended load result, registered.
- load_valid_w  out  1  one-cycle pulse with load_data_w.
- misalign_err  out  1  one-cycle pulse.
- timeout_err  out  1  sticky until Rst.

Behaviour:
- Access condition: acc = memread_m | memwrite_m. If both are high, write wins; the access is treated as a store.
- Alignment rules:
  - Misaligned: half with addr_m[0]=1; word with addr_m[1:0]!=0.
  - A misaligned access in IDLE issues no request. misalign_err pulses that cycle, stall_o=0, and the instruction proceeds as a no-op (no load_valid_w).
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE: aligned acc -> REQ; capture we, dmem_addr, be, wdata, addr[1:0], load_sel, load_uns into holding regs.
  - REQ: dmem_req=1; all dmem_* outputs held stable from holding regs. On dmem_gnt -> RESP.
  - RESP: dmem_req=0. dmem_rvalid is sampled only here; on rvalid -> DONE, and for loads register the extended data.
  - DONE: one cycle. For loads, load_valid_w=1. Then -> IDLE.
- stall_o = (state==IDLE & aligned acc) | state==REQ | state==RESP. stall_o is 0 in DONE, so the MEM instruction advances on that edge.
- Minimum latency, with gnt on first REQ cycle and rvalid on first RESP cycle:
  - acc seen at cycle t, DONE at t+3, 3 stall cycles.
  - The next MEM instruction is evaluated in IDLE at t+4.
- Byte lanes, off = addr[1:0]:
  - SB: be=4'b0001<<off, wdata={4{wdata_m[7:0]}}.
  - SH: be=off[1]?4'b1100:4'b0011, wdata={2{wdata_m[15:0]}}.
  - SW: be=4'b1111, wdata=wdata_m.
  - Loads: be=4'b1111, we=0.
- Load extraction:
  - byte = rdata[8*off+:8].
  - half = rdata[16*off[1]+:16].
  - Sign- or zero-extend per load_uns; word is passed through.
- Timeout:
  - Counter clears on IDLE->REQ and increments each cycle in REQ or RESP.
  - When the count reaches TIMEOUT_CYCLES, go to DONE; dmem_req drops, timeout_err sets.
  - For an aborted load, load_valid_w=1 and load_data_w=0.
  - A late dmem_rvalid arriving in IDLE/DONE/REQ is ignored.
- Reset values: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, stall_o=0, load_data_w=0, load_valid_w=0, misalign_err=0, timeout_err=0, counter=0.
- Reset mid-operation: the next edge returns to IDLE with dmem_req=0. Any outstanding response is dropped.
- In IDLE with no access, dmem_* outputs hold their last values except dmem_req=0. load_data_w holds its last value.

Test Plan:
- Rst high 2 cycles, then low with no access -> all outputs 0, state IDLE, stall_o=0.
- LW addr=0x100, gnt immediate, rvalid next cycle with rdata=0xDEADBEEF:
  - dmem_addr=0x100, be=1111, dmem_we=0.
  - stall_o high exactly 3 cycles; load_valid_w pulses with load_data_w=0xDEADBEEF.
- LB addr=0x103 signed then LBU same address, rdata=0x80FF1234 -> load_data_w=0xFFFFFF80, then 0x00000080.
- Store cases:
  - SB addr=0x202 wdata=0x000000AB -> be=0100, dmem_wdata=0xABABABAB, dmem_we=1.
  - SH addr=0x202 -> be=1100, dmem_wdata=0xXYXY (halfword replicated).
- LH addr=0x101 -> misalign_err pulses, dmem_req never asserts, stall_o=0, no load_valid_w.
- Timeout and reset:
  - LW with gnt held low, TIMEOUT_CYCLES=16 -> req drops after 16 cycles in REQ, timeout_err=1 sticky, load_data_w=0.
  - Separately, assert Rst during RESP -> IDLE next edge, a later rvalid is ignored.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   Sequences the data-memory access of the instruction sitting in the MEM
//   stage. One request is issued per aligned load/store. The pipeline is
//   stalled until the access completes. Store data is lane-replicated with
//   matching byte enables. Load data is extracted, extended and registered
//   for WB. Misaligned accesses are dropped and flagged. Accesses that never
//   complete are aborted after TIMEOUT_CYCLES.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   memwrite_m        MEM-stage store (wins over memread_m)
//   memread_m         MEM-stage load
//   addr_m            byte address
//   wdata_m           store data (rs2)
//   load_sel_m        00 word, 01 half, 10 byte, 11 word
//   load_uns_m        1 = zero-extend loads
//   store_sel_m       one-hot 001 SB, 010 SH, 100 SW
//   dmem_req/we/addr/be/wdata   request to memory
//   dmem_gnt          memory accepts the request this cycle
//   dmem_rvalid/rdata response (read data or write ack)
//   stall_o           freeze IF..MEM
//   load_data_w       extended load result (registered)
//   load_valid_w      one-cycle pulse alongside load_data_w
//   misalign_err      one-cycle pulse for a dropped misaligned access
//   timeout_err       sticky until reset
//   state_dbg         current FSM state for observation
//
// Handshake: a request is transferred on a cycle where dmem_req and dmem_gnt
// are both high; dmem_req and every dmem_* field stay constant from the first
// REQ cycle until that transfer. Exactly one response is expected afterwards,
// and dmem_rvalid is only honoured while waiting for it (RESP); a pulse at any
// other time is ignored.
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrite_m,
  input  logic        memread_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  input  logic [1:0]  load_sel_m,
  input  logic        load_uns_m,
  input  logic [2:0]  store_sel_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_o,
  output logic [31:0] load_data_w,
  output logic        load_valid_w,
  output logic        misalign_err,
  output logic        timeout_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       off_q;
  logic [1:0]       lsel_q;
  logic             luns_q;

  logic             acc;
  logic             size_byte;
  logic             size_half;
  logic             misaligned;
  logic             start;
  logic [3:0]       be_nxt;
  logic [31:0]      wdata_nxt;
  logic             tmo_hit;
  logic             abort;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      ext_data;

  // Request decode and lane generation from the live MEM-stage inputs.
  always_comb begin
    acc       = memread_m | memwrite_m;
    size_byte = 1'b0;
    size_half = 1'b0;
    if (memwrite_m) begin
      size_byte = (store_sel_m == 3'b001);
      size_half = (store_sel_m == 3'b010);
    end else begin
      size_byte = (load_sel_m == 2'b10);
      size_half = (load_sel_m == 2'b01);
    end

    if (size_byte)      misaligned = 1'b0;
    else if (size_half) misaligned = addr_m[0];
    else                misaligned = |addr_m[1:0];

    start = (state == IDLE) && acc && !misaligned;

    // Loads always read the full word; extraction happens on the response.
    be_nxt    = 4'b1111;
    wdata_nxt = wdata_m;
    if (memwrite_m && size_byte) begin
      be_nxt    = 4'b0001 << addr_m[1:0];
      wdata_nxt = {4{wdata_m[7:0]}};
    end else if (memwrite_m && size_half) begin
      be_nxt    = addr_m[1] ? 4'b1100 : 4'b0011;
      wdata_nxt = {2{wdata_m[15:0]}};
    end
  end

  // Load extraction uses the offset/size captured at request time, not the
  // MEM-stage inputs, which belong to the stalled instruction anyway but are
  // not relied upon here.
  always_comb begin
    rd_byte = dmem_rdata[{off_q, 3'b000} +: 8];
    rd_half = dmem_rdata[{off_q[1], 4'b0000} +: 16];
    case (lsel_q)
      2'b10:   ext_data = {{24{~luns_q & rd_byte[7]}}, rd_byte};
      2'b01:   ext_data = {{16{~luns_q & rd_half[15]}}, rd_half};
      default: ext_data = dmem_rdata;
    endcase
  end

  // The counter holds the number of REQ/RESP cycles already completed, so the
  // last permitted cycle is the one where it equals TIMEOUT_CYCLES-1. A grant
  // or response in that cycle still wins over the abort.
  always_comb begin
    tmo_hit   = (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
    abort     = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ: begin
        if (dmem_gnt) begin
          state_nxt = RESP;
        end else if (tmo_hit) begin
          state_nxt = DONE;
          abort     = 1'b1;
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          state_nxt = DONE;
        end else if (tmo_hit) begin
          state_nxt = DONE;
          abort     = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      off_q       <= '0;
      lsel_q      <= '0;
      luns_q      <= 1'b0;
      load_data_w <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        cnt        <= '0;
        dmem_we    <= memwrite_m;
        dmem_addr  <= {addr_m[31:2], 2'b00};
        dmem_be    <= be_nxt;
        dmem_wdata <= wdata_nxt;
        off_q      <= addr_m[1:0];
        lsel_q     <= load_sel_m;
        luns_q     <= load_uns_m;
      end else if (state == REQ || state == RESP) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (state == RESP && dmem_rvalid && !dmem_we)
        load_data_w <= ext_data;

      if (abort) begin
        timeout_err <= 1'b1;
        if (!dmem_we)
          load_data_w <= '0;
      end
    end
  end

  assign dmem_req     = (state == REQ);
  assign stall_o      = start || (state == REQ) || (state == RESP);
  assign load_valid_w = (state == DONE) && !dmem_we;
  assign misalign_err = (state == IDLE) && acc && misaligned;
  assign state_dbg    = state;

endmodule
